// File: rtl/trace_buf_if.sv
// Bundles the CPU trace sample inputs, the capture controls, the read port
// and the status outputs of trace_buf into one interface.
interface trace_buf_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   instr;
    logic [WIDTH-1:0]   arg;
    logic [WIDTH-1:0]   acc;
    logic               arm;
    logic               stop;
    logic               trig_en;
    logic [WIDTH-1:0]   trig_pc;
    logic               rd_req;
    logic [4*WIDTH-1:0] rd_data;
    logic               rd_valid;
    logic [ADDR_W:0]    count;
    logic [1:0]         state;
    logic               trig_hit;

    // The CPU/debug side drives samples and controls and observes the buffer.
    modport master (
        output pc, instr, arg, acc, arm, stop, trig_en, trig_pc, rd_req,
        input  rd_data, rd_valid, count, state, trig_hit
    );

    // The trace buffer consumes samples and controls and reports results.
    modport slave (
        input  pc, instr, arg, acc, arm, stop, trig_en, trig_pc, rd_req,
        output rd_data, rd_valid, count, state, trig_hit
    );
endinterface

// File: rtl/trace_buf.sv
// Triggered debug trace capture: records a window of CPU samples into an
// internal buffer after a trigger, then drains them in capture order through
// a request/valid read port with one cycle of latency.
module trace_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    trace_buf_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] LAST_FILL = (ADDR_W + 1)'(DEPTH - 1);

    state_e             state_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0]  rd_ptr_q;
    logic [ADDR_W:0]    count_q;
    logic [4*WIDTH-1:0] rd_data_q;
    logic               rd_valid_q;
    logic               trig_hit_q;
    logic [4*WIDTH-1:0] mem_q [DEPTH];

    logic [4*WIDTH-1:0] sample_d;
    logic               trig_d;
    logic               wr_en_d;
    logic               rd_en_d;

    // Decode this cycle's trigger, write and read-accept conditions; stop
    // beats a trigger, and an arm in DONE drops any read in the same cycle.
    always_comb begin
        sample_d = {bus.pc, bus.instr, bus.arg, bus.acc};
        trig_d   = (state_q == ARMED) && !bus.stop &&
                   (!bus.trig_en || (bus.pc == bus.trig_pc));
        wr_en_d  = trig_d || ((state_q == CAPT) && !bus.stop);
        rd_en_d  = (state_q == DONE) && !bus.arm && bus.rd_req &&
                   (count_q != '0);
    end

    // Sample storage; contents are meaningless after reset so it has none.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_d) begin
            mem_q[wr_ptr_q] <= sample_d;
        end
    end

    // Capture/drain state machine with pointers, fill level and read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            trig_hit_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_d;
            trig_hit_q <= trig_d;

            if (wr_en_d) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 1'b1;
            end

            if (rd_en_d) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                count_q   <= count_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_q  <= ARMED;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                    end
                end
                ARMED: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                    end else if (trig_d) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    if (bus.stop || (count_q == LAST_FILL)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.arm) begin
                        state_q  <= ARMED;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.state    = state_q;
    assign bus.trig_hit = trig_hit_q;
endmodule

// File: doc/trace_buf.md
Name: trace_buf

Overview:
- Debug trace capture stage sitting directly downstream of the CPU top.
- Consumes the CPU debug outputs (pc, instr, arg, acc) every clock, stores a triggered window of samples in an internal buffer, then drains them through a request/valid read port.
- Used by the bench and by the board-level debug path to inspect program execution without probing internal nets.

Parameters:
- WIDTH, 8, width of each traced field; must match the CPU data width.
- DEPTH, 16, number of buffer entries; power of two.
- ADDR_W, 4, log2(DEPTH); buffer pointer width.

Ports:
- clk  input  1  system clock, same clock as the CPU.
- rst  input  1  synchronous, active-high reset.
- pc  input  WIDTH  CPU program counter of the current cycle.
- instr  input  WIDTH  CPU instruction of the current cycle.
- arg  input  WIDTH  CPU instruction argument of the current cycle.
- acc  input  WIDTH  CPU accumulator value of the current cycle.
- arm  input  1  one-cycle pulse; starts a new capture.
- stop  input  1  one-cycle pulse; aborts arming or ends capture early.
- trig_en  input  1  1 = wait for pc==trig_pc; 0 = trigger immediately.
- trig_pc  input  WIDTH  trigger address.
- rd_req  input  1  read request, one entry per asserted cycle.
- rd_data  output  4*WIDTH  {pc, instr, arg, acc}, with pc in the MSBs.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.
- count  output  ADDR_W+1  number of stored, unread entries.
- state  output  2  IDLE=0, ARMED=1, CAPT=2, DONE=3.
- trig_hit  output  1  one-cycle pulse in the cycle after the trigger sample is written.

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs and pointers are registered.
- Reset values: state=IDLE, count=0, wr_ptr=0, rd_ptr=0, rd_data=0, rd_valid=0, trig_hit=0.
- Reset overrides everything, including mid-capture and mid-read. Buffer contents are don't-care after reset.
- IDLE:
  - arm → ARMED. In the same edge, wr_ptr, rd_ptr and count clear to 0.
  - stop and rd_req are ignored.
- ARMED:
  - Trigger condition: (trig_en==0) or (pc==trig_pc), evaluated on the current-cycle inputs.
  - On trigger, the current sample is written as entry 0, count→1, trig_hit=1 in the next cycle, and state→CAPT.
  - stop without trigger → IDLE, nothing written.
  - stop and trigger in the same cycle → stop wins.
  - arm is ignored.
- CAPT:
  - Writes one sample per cycle at wr_ptr; wr_ptr and count increment.
  - When a write makes count==DEPTH, state→DONE. No further writes occur, so there is no wrap or overwrite.
  - stop → DONE with no write that cycle.
  - arm is ignored.
  - rd_req is ignored, and rd_valid stays 0.
- DONE:
  - rd_req with count>0: rd_data = entry[rd_ptr] registered in the next cycle, rd_valid=1 for exactly that cycle, rd_ptr increments, count decrements.
  - Read latency is 1 cycle. Back-to-back rd_req gives one entry per cycle.
  - rd_req with count==0: rd_valid=0, rd_data holds its last value.
  - arm → ARMED with pointers and count cleared. An rd_req in the same cycle is dropped.
- rd_data holds its value between reads. rd_valid is 0 in every cycle not directly following an accepted read.
- Entries read out in capture order (FIFO). rd_ptr wraps modulo DEPTH.
- count never exceeds DEPTH and never underflows.

Test Plan:
- rst held 2 cycles, then arm with trig_en=0, pc sequence 0x00..0x0F → trig_hit in cycle 2, state=DONE after 16 writes, count=16. 16 back-to-back rd_req → rd_valid 16 cycles; rd_data[31:24]=0x00..0x0F in order; count ends at 0.
- arm, trig_en=1, trig_pc=0x05, pc counting from 0x00 → first entry has pc=0x05. Entries 0x05..0x14 are stored; no entry has pc<0x05.
- arm, trigger at pc=0x03, stop after 4 captured cycles → state=DONE, count=4. Reads return pc 0x03..0x06, and a 5th rd_req gives rd_valid=0.
- arm with trig_en=1, trig_pc=0xAA that never occurs, then stop → state=IDLE, count=0.
- stop and pc==trig_pc in the same ARMED cycle → state=IDLE, no write.
- rst asserted in CAPT at count=7 → next cycle state=0, count=0, rd_valid=0. rd_req in DONE while arm is pulsed → no rd_valid, state=ARMED, count=0.
